// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI configuration sequencer.
package spi_seq_pkg;

  typedef enum logic [1:0] {
    OP_END           = 2'd0,
    OP_DAC_WR        = 2'd1,
    OP_ADC_WR        = 2'd2,
    OP_ADC_WR_VERIFY = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_ISSUE, ST_WAIT_ACK, ST_WAIT_DONE,
    ST_RD_ISSUE, ST_RD_ACK, ST_RD_DONE, ST_CHECK, ST_FINISH
  } state_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_RISE   = 2'd1;
  localparam logic [1:0] ERR_FALL   = 2'd2;
  localparam logic [1:0] ERR_VERIFY = 2'd3;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 30;
  localparam int ADDR_HI = 26;
  localparam int ADDR_LO = 16;
  localparam int DATA_HI = 11;
  localparam int DATA_LO = 0;

  // Only the fields the sequencer acts on; DAC/ADC narrow them further.
  typedef struct packed {
    op_e         op;
    logic [10:0] addr;
    logic [11:0] data;
  } entry_t;

endpackage

// File: rtl/spi_seq_table.sv
// Entry table: single write port, registered read port, no reset on contents.
module spi_seq_table #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/spi_config_sequencer.sv
// Walks a table of DAC/ADC writes through the SPI controller handshake and
// arbitrates the controller between the sequencer and the direct host path.
module spi_config_sequencer
  import spi_seq_pkg::*;
#(
  parameter  int unsigned DEPTH   = 16,
  parameter  int unsigned TIMEOUT = 1023,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          sys_clk,
  input  logic          reset_n,
  input  logic          tbl_wr_en,
  input  logic [AW-1:0] tbl_addr,
  input  logic [31:0]   tbl_data,
  input  logic          start,
  input  logic          abort,
  input  logic          host_dac_request_write,
  input  logic          host_adc_request_write,
  input  logic          host_adc_request_read,
  input  logic [4:0]    host_dac_address,
  input  logic [11:0]   host_dac_data,
  input  logic [10:0]   host_adc_address,
  input  logic [7:0]    host_adc_data,
  output logic          host_busy,
  output logic          dac_request_write,
  output logic          adc_request_write,
  output logic          adc_request_read,
  output logic [4:0]    dac_address,
  output logic [11:0]   dac_data,
  output logic [10:0]   adc_address,
  output logic [7:0]    adc_data,
  input  logic [7:0]    adc_data_readback,
  input  logic          spi_busy,
  output logic          running,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code,
  output logic [AW-1:0] err_index
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e        state_q;
  entry_t        ent_q, tbl_ent;
  logic [AW-1:0] idx_q, err_index_q, rd_addr;
  logic [TW-1:0] tmo_q;
  logic [1:0]    err_code_q;
  logic          running_q, done_q, error_q, abort_q;
  logic          dac_req_q, adc_wr_q, adc_rd_q;
  logic [31:0]   tbl_rdata;
  logic          tmo_hit, stop_now, unused_bits;

  // FETCH is entered only from IDLE (entry 0) or on advance (idx+1), so the
  // read address can be presented one cycle early without extra state.
  assign rd_addr  = (state_q == ST_IDLE) ? '0 : idx_q + AW'(1);
  assign tbl_ent  = {tbl_rdata[OP_HI:OP_LO], tbl_rdata[ADDR_HI:ADDR_LO], tbl_rdata[DATA_HI:DATA_LO]};
  assign unused_bits = ^{tbl_rdata[29:27], tbl_rdata[15:12]};
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
  assign stop_now = abort_q | abort | (idx_q == AW'(DEPTH - 1));

  spi_seq_table #(.DEPTH(DEPTH)) u_table (
    .clk_i     (sys_clk),
    .wr_en_i   (tbl_wr_en & ~running_q),
    .wr_addr_i (tbl_addr),
    .wr_data_i (tbl_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (tbl_rdata)
  );

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ent_q       <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      abort_q     <= 1'b0;
      dac_req_q   <= 1'b0;
      adc_wr_q    <= 1'b0;
      adc_rd_q    <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_index_q <= '0;
    end else begin
      done_q    <= 1'b0;
      dac_req_q <= 1'b0;
      adc_wr_q  <= 1'b0;
      adc_rd_q  <= 1'b0;
      if (abort) abort_q <= 1'b1;
      case (state_q)
        ST_IDLE: if (start) begin
          error_q     <= 1'b0;
          err_code_q  <= ERR_NONE;
          err_index_q <= '0;
          idx_q       <= '0;
          abort_q     <= 1'b0;
          running_q   <= 1'b1;
          state_q     <= ST_FETCH;
        end
        ST_FETCH: begin
          ent_q   <= tbl_ent;
          state_q <= (tbl_ent.op == OP_END) ? ST_FINISH : ST_ISSUE;
        end
        ST_ISSUE, ST_RD_ISSUE: if (!spi_busy) begin
          tmo_q <= '0;
          if (state_q == ST_RD_ISSUE) begin
            adc_rd_q <= 1'b1;
            state_q  <= ST_RD_ACK;
          end else begin
            dac_req_q <= (ent_q.op == OP_DAC_WR);
            adc_wr_q  <= (ent_q.op != OP_DAC_WR);
            state_q   <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK, ST_RD_ACK: begin
          if (spi_busy) begin
            tmo_q   <= '0;
            state_q <= (state_q == ST_WAIT_ACK) ? ST_WAIT_DONE : ST_RD_DONE;
          end else if (tmo_hit) begin
            error_q     <= 1'b1;
            err_code_q  <= ERR_RISE;
            err_index_q <= idx_q;
            running_q   <= 1'b0;
            abort_q     <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_WAIT_DONE, ST_RD_DONE: begin
          if (!spi_busy) begin
            if (state_q == ST_RD_DONE)                state_q <= ST_CHECK;
            else if (ent_q.op == OP_ADC_WR_VERIFY)    state_q <= ST_RD_ISSUE;
            else if (stop_now)                        state_q <= ST_FINISH;
            else begin
              idx_q   <= idx_q + AW'(1);
              state_q <= ST_FETCH;
            end
          end else if (tmo_hit) begin
            error_q     <= 1'b1;
            err_code_q  <= ERR_FALL;
            err_index_q <= idx_q;
            running_q   <= 1'b0;
            abort_q     <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_CHECK: begin
          if (adc_data_readback != ent_q.data[7:0]) begin
            error_q     <= 1'b1;
            err_code_q  <= ERR_VERIFY;
            err_index_q <= idx_q;
            running_q   <= 1'b0;
            abort_q     <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (stop_now) begin
            state_q <= ST_FINISH;
          end else begin
            idx_q   <= idx_q + AW'(1);
            state_q <= ST_FETCH;
          end
        end
        ST_FINISH: begin
          done_q    <= ~error_q;
          running_q <= 1'b0;
          abort_q   <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign host_busy = spi_busy | running_q;
  assign running   = running_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign err_index = err_index_q;

  // Host path is a pure combinational pass-through whenever the sequencer is idle.
  assign dac_request_write = running_q ? dac_req_q            : host_dac_request_write;
  assign adc_request_write = running_q ? adc_wr_q             : host_adc_request_write;
  assign adc_request_read  = running_q ? adc_rd_q             : host_adc_request_read;
  assign dac_address       = running_q ? ent_q.addr[4:0]      : host_dac_address;
  assign dac_data          = running_q ? ent_q.data           : host_dac_data;
  assign adc_address       = running_q ? ent_q.addr           : host_adc_address;
  assign adc_data          = running_q ? ent_q.data[7:0]      : host_adc_data;

endmodule

// File: tb/tb_spi_config_sequencer.sv
// Randomized + directed bench: a behavioural SPI controller model answers the
// handshake and a table-walk reference model predicts transactions and status.
module tb_spi_config_sequencer;
  localparam int DEPTH = 8;
  localparam int TIMEOUT = 20;

  logic        sys_clk = 1'b0, reset_n = 1'b0;
  logic        tbl_wr_en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [2:0]  tbl_addr = '0;
  logic [31:0] tbl_data = '0;
  logic        host_dac_request_write = 1'b0, host_adc_request_write = 1'b0, host_adc_request_read = 1'b0;
  logic [4:0]  host_dac_address = '0;
  logic [11:0] host_dac_data = '0;
  logic [10:0] host_adc_address = '0;
  logic [7:0]  host_adc_data = '0;
  logic        host_busy, dac_request_write, adc_request_write, adc_request_read;
  logic [4:0]  dac_address;
  logic [11:0] dac_data;
  logic [10:0] adc_address;
  logic [7:0]  adc_data, adc_data_readback;
  logic        spi_busy, running, done, error;
  logic [1:0]  err_code;
  logic [2:0]  err_index;

  always #10 sys_clk = ~sys_clk;

  spi_config_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .tbl_wr_en(tbl_wr_en), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .start(start), .abort(abort),
    .host_dac_request_write(host_dac_request_write), .host_adc_request_write(host_adc_request_write),
    .host_adc_request_read(host_adc_request_read), .host_dac_address(host_dac_address),
    .host_dac_data(host_dac_data), .host_adc_address(host_adc_address), .host_adc_data(host_adc_data),
    .host_busy(host_busy), .dac_request_write(dac_request_write), .adc_request_write(adc_request_write),
    .adc_request_read(adc_request_read), .dac_address(dac_address), .dac_data(dac_data),
    .adc_address(adc_address), .adc_data(adc_data), .adc_data_readback(adc_data_readback),
    .spi_busy(spi_busy), .running(running), .done(done), .error(error),
    .err_code(err_code), .err_index(err_index)
  );

  int nvec = 0, nerr = 0, done_cnt = 0;
  logic [31:0] tbl [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] obs_q [$];
  logic [7:0]  adc_mem [2048];
  bit          ack_en = 1'b1, hold_busy = 1'b0, exp_err, exp_done;
  logic [7:0]  corrupt = 8'h0;
  logic [1:0]  exp_code;
  logic [2:0]  exp_idx;

  function automatic logic [31:0] pk(input logic [1:0] k, input logic [10:0] a, input logic [11:0] d);
    return {6'b0, k, 1'b0, a, d};
  endfunction

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [10:0] a, input logic [11:0] d);
    return {op, 3'b0, a, 4'b0, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: walk the table in order, stop at END, the last slot, or the first bad readback.
  function automatic void model();
    logic [1:0] op;
    exp_q.delete(); exp_err = 1'b0; exp_code = 2'd0; exp_idx = 3'd0;
    for (int i = 0; i < DEPTH; i++) begin
      op = tbl[i][31:30];
      if (op == 2'd0) break;
      if (op == 2'd1) exp_q.push_back(pk(2'd1, {6'b0, tbl[i][20:16]}, tbl[i][11:0]));
      else            exp_q.push_back(pk(2'd2, tbl[i][26:16], {4'b0, tbl[i][7:0]}));
      if (op == 2'd3) begin
        exp_q.push_back(pk(2'd3, tbl[i][26:16], 12'h0));
        if (corrupt != 8'h0) begin exp_err = 1'b1; exp_code = 2'd3; exp_idx = 3'(i); break; end
      end
    end
    exp_done = !exp_err;
  endfunction

  // Monitor: one record per request-high cycle, so a stretched pulse shows up as a duplicate.
  initial forever begin
    @(posedge sys_clk); #1;
    if (done) done_cnt++;
    if (dac_request_write) obs_q.push_back(pk(2'd1, {6'b0, dac_address}, dac_data));
    if (adc_request_write) obs_q.push_back(pk(2'd2, adc_address, {4'b0, adc_data}));
    if (adc_request_read)  obs_q.push_back(pk(2'd3, adc_address, 12'h0));
  end

  // Controller model: random ack latency and busy length; reads return stored data ^ corrupt.
  initial begin
    logic [10:0] ra;
    logic        rrd;
    spi_busy = 1'b0; adc_data_readback = 8'h0;
    forever begin
      @(posedge sys_clk); #1;
      if (ack_en && reset_n && (dac_request_write || adc_request_write || adc_request_read)) begin
        ra = adc_address; rrd = adc_request_read;
        if (adc_request_write) adc_mem[ra] = adc_data;
        repeat ($urandom_range(0, 2)) begin @(posedge sys_clk); #1; end
        spi_busy = 1'b1;
        if (rrd) adc_data_readback = adc_mem[ra] ^ corrupt;
        while (hold_busy) begin @(posedge sys_clk); #1; end
        repeat ($urandom_range(1, 4)) begin @(posedge sys_clk); #1; end
        spi_busy = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic clr_tbl();
    for (int i = 0; i < DEPTH; i++) tbl[i] = 32'h0;
  endtask

  task automatic load_tbl();
    for (int i = 0; i < DEPTH; i++) begin
      tbl_wr_en = 1'b1; tbl_addr = 3'(i); tbl_data = tbl[i];
      @(posedge sys_clk); #1;
    end
    tbl_wr_en = 1'b0;
  endtask

  task automatic kick();
    done_cnt = 0; obs_q.delete();
    start = 1'b1; @(posedge sys_clk); #1; start = 1'b0;
    chk("running_after_start", 32'(running), 32'd1);
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while (running && c < maxc) begin @(posedge sys_clk); #1; c++; end
    chk("run_terminates", 32'(running), 32'd0);
    repeat (6) begin @(posedge sys_clk); #1; end
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_ntxn"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) chk({tag, "_txn"}, obs_q[i], exp_q[i]);
    chk({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_err_code"}, 32'(err_code), 32'(exp_code));
    chk({tag, "_err_index"}, 32'(err_index), 32'(exp_idx));
  endtask

  // poke: 1 = table write while running, 2 = second start while running
  task automatic run(input string tag, input int poke);
    load_tbl(); model(); kick();
    if (poke == 1) begin
      tbl_wr_en = 1'b1; tbl_addr = 3'd1; tbl_data = mk(2'd1, 11'h01F, 12'h123);
      @(posedge sys_clk); #1; tbl_wr_en = 1'b0;
    end else if (poke == 2) begin
      repeat (5) begin @(posedge sys_clk); #1; end
      start = 1'b1; @(posedge sys_clk); #1; start = 1'b0;
    end
    wait_idle(600);
    check_results(tag);
  endtask

  initial begin
    int c;
    logic [1:0] op;
    repeat (3) begin @(posedge sys_clk); #1; end
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_err_index", 32'(err_index), 32'd0);
    chk("rst_reqs", 32'({dac_request_write, adc_request_write, adc_request_read}), 32'd0);
    chk("rst_host_busy", 32'(host_busy), 32'd0);
    reset_n = 1'b1;
    @(posedge sys_clk); #1;

    clr_tbl(); tbl[0] = mk(2'd1, 11'h003, 12'hABC);
    run("dac_single", 1);

    clr_tbl(); tbl[0] = mk(2'd3, 11'h215, 12'h05A); corrupt = 8'h00;
    run("verify_ok", 0);
    corrupt = 8'h01;
    run("verify_bad", 0);
    corrupt = 8'h00;

    for (int i = 0; i < DEPTH; i++) tbl[i] = mk(2'd1, 11'($urandom), 12'($urandom));
    run("full_table", 2);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] = $urandom;
        op = (i > 0 && $urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
        tbl[i][31:30] = op;
      end
      corrupt = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h0;
      run("random", 0);
    end
    corrupt = 8'h00;

    // abort during entry 1: entry 1 completes, nothing after it
    for (int i = 0; i < DEPTH; i++) tbl[i] = mk(2'd1, 11'($urandom), 12'($urandom));
    load_tbl(); model(); kick();
    c = 0;
    while (obs_q.size() < 2 && c < 200) begin @(posedge sys_clk); #1; c++; end
    abort = 1'b1; @(posedge sys_clk); #1; abort = 1'b0;
    wait_idle(600);
    exp_q = exp_q[0:1];
    check_results("abort");

    // host request is blocked while running, passes straight through once idle
    load_tbl(); kick();
    repeat (4) begin @(posedge sys_clk); #1; end
    host_adc_request_read = 1'b1; host_adc_address = 11'h123; #1;
    chk("host_blocked_req", 32'(adc_request_read), 32'd0);
    chk("host_blocked_busy", 32'(host_busy), 32'd1);
    host_adc_request_read = 1'b0;
    wait_idle(600);
    ack_en = 1'b0;
    host_adc_request_read = 1'b1; #1;
    chk("host_pass_req", 32'(adc_request_read), 32'd1);
    chk("host_pass_addr", 32'(adc_address), 32'h123);
    host_adc_request_read = 1'b0; host_adc_address = 11'h0;
    @(posedge sys_clk); #1;

    // busy never rises: code 1 exactly TIMEOUT cycles after the request, no retries
    clr_tbl(); tbl[0] = mk(2'd1, 11'h007, 12'h0F0); tbl[1] = mk(2'd1, 11'h008, 12'h0F1);
    load_tbl(); kick();
    c = 0;
    while (!dac_request_write && c < 20) begin @(posedge sys_clk); #1; c++; end
    c = 0;
    while (!error && c < 100) begin @(posedge sys_clk); #1; c++; end
    chk("rise_tmo_cycles", 32'(c), 32'(TIMEOUT));
    chk("rise_tmo_code", 32'(err_code), 32'd1);
    chk("rise_tmo_index", 32'(err_index), 32'd0);
    repeat (30) begin @(posedge sys_clk); #1; end
    chk("rise_tmo_nreq", 32'(obs_q.size()), 32'd1);
    chk("rise_tmo_done", 32'(done_cnt), 32'd0);
    chk("rise_tmo_running", 32'(running), 32'd0);
    ack_en = 1'b1;

    // busy never falls: code 2
    hold_busy = 1'b1; kick();
    c = 0;
    while (!error && c < 100) begin @(posedge sys_clk); #1; c++; end
    chk("fall_tmo_code", 32'(err_code), 32'd2);
    chk("fall_tmo_done", 32'(done_cnt), 32'd0);
    hold_busy = 1'b0;
    repeat (8) begin @(posedge sys_clk); #1; end

    // reset while in WAIT_DONE drops everything immediately
    hold_busy = 1'b1; kick();
    c = 0;
    while (!spi_busy && c < 20) begin @(posedge sys_clk); #1; c++; end
    @(posedge sys_clk); #1;
    reset_n = 1'b0; #1;
    chk("midrst_running", 32'(running), 32'd0);
    chk("midrst_reqs", 32'({dac_request_write, adc_request_write, adc_request_read}), 32'd0);
    chk("midrst_status", 32'({done, error, err_code}), 32'd0);
    hold_busy = 1'b0;
    repeat (8) begin @(posedge sys_clk); #1; end
    reset_n = 1'b1;
    @(posedge sys_clk); #1;

    clr_tbl(); tbl[0] = mk(2'd2, 11'h3C1, 12'h0A5); tbl[1] = mk(2'd1, 11'h01E, 12'h777);
    run("after_reset", 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
